// File: rtl/fleet_placement_checker.sv
// fleet_placement_checker: sequential fleet placement validator.
// Walks every ship cell one per clock, checking bounds, blocked cells and
// overlap, and builds the resulting occupancy map.
// Optional build macro: CHECKER_FULL_SCAN_EN (scan every ship instead of
// stopping at the first error).
module fleet_placement_checker #(
  parameter int BOARD_DIM = 10,
  parameter int NUM_SHIPS = 5,
  parameter int MAX_LEN   = 5,
  parameter int POS_W     = $clog2(BOARD_DIM*BOARD_DIM),
  parameter int IDX_W     = $clog2(NUM_SHIPS),
  parameter int LEN_W     = $clog2(MAX_LEN+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [IDX_W-1:0]               load_idx,
  input  logic [POS_W-1:0]               load_pos,
  input  logic                           load_vert,
  input  logic [LEN_W-1:0]               load_len,
  input  logic [BOARD_DIM*BOARD_DIM-1:0] board_blocked,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           valid_out,
  output logic [IDX_W-1:0]               err_ship,
  output logic [1:0]                     err_code,
  output logic [NUM_SHIPS-1:0]           err_mask,
  output logic [BOARD_DIM*BOARD_DIM-1:0] occ_map
);

  localparam int CELLS = BOARD_DIM*BOARD_DIM;

  typedef enum logic [1:0] {IDLE, BOUND, WALK, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [POS_W-1:0]       pos_reg [NUM_SHIPS];
  logic [NUM_SHIPS-1:0]   vert_reg;
  logic [LEN_W-1:0]       len_reg [NUM_SHIPS];
  logic [CELLS-1:0]       blocked_reg;
  logic [CELLS-1:0]       occ_reg;
  logic [IDX_W-1:0]       ship_reg;
  logic [LEN_W-1:0]       k_reg;
  logic                   skip_reg;      // current ship failed BOUND: walk without checking
  logic [IDX_W-1:0]       err_ship_reg;
  logic [1:0]             err_code_reg;
  logic [NUM_SHIPS-1:0]   err_mask_reg;
  logic                   valid_reg;

  // Decoded actions from the FSM
  logic                   load_ok, err_now, mark, go_walk, skip_now, k_inc, ship_inc;
  logic [1:0]             err_code_now;
  logic                   pass_now;

  // Current ship geometry, evaluated in integer arithmetic to avoid overflow
  int                     pos_i, len_i, row_i, col_i, k_i, cell_i;
  logic                   cur_vert, oob, last_ship, last_cell, hit_blocked, hit_occ;
  logic [POS_W-1:0]       cell_idx;

  assign load_ok = load && (state_reg == IDLE) && (int'(load_idx) < NUM_SHIPS);

  // Ship slot storage: cleared on reset, written only by an accepted load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        pos_reg[i]  <= '0;
        vert_reg[i] <= 1'b0;
        len_reg[i]  <= '0;
      end
    end else if (load_ok) begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        if (load_idx == IDX_W'(i)) begin
          pos_reg[i]  <= load_pos;
          vert_reg[i] <= load_vert;
          len_reg[i]  <= load_len;
        end
      end
    end
  end

  // Geometry of the ship/cell under inspection
  always_comb begin
    pos_i       = int'(pos_reg[ship_reg]);
    len_i       = int'(len_reg[ship_reg]);
    cur_vert    = vert_reg[ship_reg];
    k_i         = int'(k_reg);
    row_i       = pos_i / BOARD_DIM;
    col_i       = pos_i % BOARD_DIM;
    oob         = (len_i > MAX_LEN) || (pos_i >= CELLS) ||
                  (!cur_vert && (col_i + len_i > BOARD_DIM)) ||
                  ( cur_vert && (row_i + len_i > BOARD_DIM));
    cell_i      = cur_vert ? (pos_i + k_i*BOARD_DIM) : (pos_i + k_i);
    cell_idx    = POS_W'(cell_i);
    hit_blocked = (cell_i < CELLS) && blocked_reg[cell_idx];
    hit_occ     = (cell_i < CELLS) && occ_reg[cell_idx];
    last_ship   = (int'(ship_reg) == NUM_SHIPS-1);
    last_cell   = (k_i == len_i - 1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state and per-cycle datapath actions
  always_comb begin
    state_next   = state_reg;
    err_now      = 1'b0;
    err_code_now = 2'b00;
    mark         = 1'b0;
    go_walk      = 1'b0;
    skip_now     = 1'b0;
    k_inc        = 1'b0;
    ship_inc     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = BOUND;
      end
      BOUND: begin
        if (len_i == 0) begin
          ship_inc   = !last_ship;
          state_next = last_ship ? DONE : BOUND;
        end else if (oob) begin
          err_now      = 1'b1;
          err_code_now = 2'b01;
`ifdef CHECKER_FULL_SCAN_EN
          go_walk      = 1'b1;
          skip_now     = 1'b1;
          state_next   = WALK;
`else
          state_next   = DONE;
`endif
        end else begin
          go_walk    = 1'b1;
          state_next = WALK;
        end
      end
      WALK: begin
        if (!skip_reg) begin
          if (hit_blocked) begin
            err_now      = 1'b1;
            err_code_now = 2'b10;
          end else if (hit_occ) begin
            err_now      = 1'b1;
            err_code_now = 2'b11;
          end else begin
            mark = 1'b1;
          end
        end
`ifndef CHECKER_FULL_SCAN_EN
        if (err_now) begin
          state_next = DONE;
        end else
`endif
        if (last_cell) begin
          ship_inc   = !last_ship;
          state_next = last_ship ? DONE : BOUND;
        end else begin
          k_inc = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CHECKER_FULL_SCAN_EN
  assign pass_now = ~|err_mask_reg;
`else
  assign pass_now = (err_code_reg == 2'b00);
`endif

  // Check datapath: capture at start, walk counters, occupancy and error latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blocked_reg  <= '0;
      occ_reg      <= '0;
      ship_reg     <= '0;
      k_reg        <= '0;
      skip_reg     <= 1'b0;
      err_ship_reg <= '0;
      err_code_reg <= 2'b00;
      err_mask_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) begin
        blocked_reg  <= board_blocked;
        occ_reg      <= '0;
        ship_reg     <= '0;
        err_ship_reg <= '0;
        err_code_reg <= 2'b00;
        err_mask_reg <= '0;
        valid_reg    <= 1'b0;
      end
      if (go_walk) begin
        k_reg    <= '0;
        skip_reg <= skip_now;
      end
      if (k_inc)    k_reg    <= k_reg + 1'b1;
      if (ship_inc) ship_reg <= ship_reg + 1'b1;
      if (mark)     occ_reg[cell_idx] <= 1'b1;
      if (err_now) begin
        err_mask_reg[ship_reg] <= 1'b1;
        // err_code of 00 means nothing latched yet, so only the first error sticks
        if (err_code_reg == 2'b00) begin
          err_ship_reg <= ship_reg;
          err_code_reg <= err_code_now;
        end
      end
      if (state_reg == DONE) valid_reg <= pass_now;
    end
  end

  assign busy      = (state_reg == BOUND) || (state_reg == WALK);
  assign done      = (state_reg == DONE);
  assign valid_out = (state_reg == DONE) ? pass_now : valid_reg;
  assign err_ship  = err_ship_reg;
  assign err_code  = err_code_reg;
  assign err_mask  = err_mask_reg;
  assign occ_map   = occ_reg;

endmodule

// File: tb/tb_fleet_placement_checker.sv
// tb_fleet_placement_checker: table-driven directed check of the fleet
// placement checker, plus hand-written protocol and reset sequences.
// Expectations follow CHECKER_FULL_SCAN_EN when it is defined.
module tb_fleet_placement_checker;

  localparam int NS = 5;
  localparam int PW = 7;
  localparam int IW = 3;
  localparam int LW = 3;
`ifdef CHECKER_FULL_SCAN_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [IW-1:0] load_idx = '0;
  logic [PW-1:0] load_pos = '0;
  logic          load_vert = 1'b0;
  logic [LW-1:0] load_len = '0;
  logic [99:0]   board_blocked = '0;
  logic          start = 1'b0;
  logic          busy, done, valid_out;
  logic [IW-1:0] err_ship;
  logic [1:0]    err_code;
  logic [NS-1:0] err_mask;
  logic [99:0]   occ_map;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string           name;
    logic [4:0][6:0] pos;
    logic [4:0]      vert;
    logic [4:0][2:0] len;
    logic [99:0]     blk;
    int              lat;
    logic            vld;
    logic [2:0]      es;
    logic [1:0]      ec;
    logic [4:0]      em;
    logic [99:0]     occ;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  fleet_placement_checker dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_idx(load_idx),
    .load_pos(load_pos), .load_vert(load_vert), .load_len(load_len),
    .board_blocked(board_blocked), .start(start), .busy(busy), .done(done),
    .valid_out(valid_out), .err_ship(err_ship), .err_code(err_code),
    .err_mask(err_mask), .occ_map(occ_map)
  );

  function automatic logic [99:0] cells(input int s, input int n, input int step);
    logic [99:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[s + i*step] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_slot(input int idx, input logic [6:0] p, input logic v, input logic [2:0] l);
    load = 1'b1; load_idx = IW'(idx); load_pos = p; load_vert = v; load_len = l;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic load_fleet(input vec_t v);
    for (int i = 0; i < NS; i++) load_slot(i, v.pos[i], v.vert[i], v.len[i]);
  endtask

  // Start a check and count cycles until done; at cycle 'poke' try start+load while busy
  task automatic run_check(input int poke, output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; load = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1));
    lat = 0;
    do begin
      if (lat == poke) begin
        start = 1'b1; load = 1'b1; load_idx = '0; load_pos = 7'd97; load_vert = 1'b0; load_len = 3'd5;
      end
      @(posedge clk); #1;
      start = 1'b0; load = 1'b0;
      lat++;
    end while (!done && lat < 200);
    chk("done_seen", 128'(done), 128'(1));
  endtask

  task automatic check_result(input string nm, input int lat, input vec_t v);
    chk({nm, "_latency"},  128'(lat),       128'(v.lat));
    chk({nm, "_valid"},    128'(valid_out), 128'(v.vld));
    chk({nm, "_err_ship"}, 128'(err_ship),  128'(v.es));
    chk({nm, "_err_code"}, 128'(err_code),  128'(v.ec));
    chk({nm, "_err_mask"}, 128'(err_mask),  128'(v.em));
    chk({nm, "_occ_map"},  128'(occ_map),   128'(v.occ));
    $display("[TB] %s: lat=%0d valid=%0b err_ship=%0d err_code=%b err_mask=%b",
             nm, lat, valid_out, err_ship, err_code, err_mask);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 128'(done),      128'(0));
    chk({nm, "_valid_hold"}, 128'(valid_out), 128'(v.vld));
  endtask

  initial begin
    int   lat;
    logic saw_done;
    vec_t v;
    logic [99:0] base;

    base = cells(0,2,1) | cells(10,3,1) | cells(20,3,1) | cells(30,4,1);
    vecs[0] = '{"pass_fleet", {7'd40,7'd30,7'd20,7'd10,7'd0}, 5'b00000, {3'd5,3'd4,3'd3,3'd3,3'd2},
                '0, 22, 1'b1, 3'd0, 2'b00, 5'b00000, base | cells(40,5,1)};
    vecs[1] = '{"oob_ship4", {7'd97,7'd30,7'd20,7'd10,7'd0}, 5'b00000, {3'd5,3'd4,3'd3,3'd3,3'd2},
                '0, FULL ? 22 : 17, 1'b0, 3'd4, 2'b01, 5'b10000, base};
    vecs[2] = '{"overlap_vert", {7'd0,7'd0,7'd0,7'd1,7'd0}, 5'b00010, {3'd0,3'd0,3'd0,3'd3,3'd2},
                '0, FULL ? 10 : 5, 1'b0, 3'd1, 2'b11, 5'b00010,
                FULL ? (cells(0,2,1) | cells(11,2,10)) : cells(0,2,1)};
    vecs[3] = '{"blocked_44", {7'd40,7'd30,7'd20,7'd10,7'd0}, 5'b00000, {3'd5,3'd4,3'd3,3'd3,3'd2},
                cells(44,1,1), 22, 1'b0, 3'd4, 2'b10, 5'b10000, base | cells(40,4,1)};
    vecs[4] = '{"len_too_big", {7'd0,7'd0,7'd20,7'd10,7'd0}, 5'b00000, {3'd0,3'd0,3'd6,3'd3,3'd2},
                '0, FULL ? 16 : 8, 1'b0, 3'd2, 2'b01, 5'b00100, cells(0,2,1) | cells(10,3,1)};
    vecs[5] = '{"vert_past_bottom", {7'd0,7'd0,7'd0,7'd0,7'd70}, 5'b00001, {3'd0,3'd0,3'd0,3'd0,3'd4},
                '0, FULL ? 9 : 1, 1'b0, 3'd0, 2'b01, 5'b00001, '0};
    vecs[6] = '{"edges_pass", {7'd0,7'd0,7'd0,7'd95,7'd9}, 5'b00001, {3'd0,3'd0,3'd0,3'd5,3'd5},
                '0, 15, 1'b1, 3'd0, 2'b00, 5'b00000, cells(9,5,10) | cells(95,5,1)};
    vecs[7] = '{"oob_plus_overlap", {7'd97,7'd30,7'd20,7'd1,7'd0}, 5'b00000, {3'd5,3'd4,3'd3,3'd3,3'd2},
                '0, FULL ? 22 : 5, 1'b0, 3'd1, 2'b11, FULL ? 5'b10010 : 5'b00010,
                FULL ? (cells(0,4,1) | cells(20,3,1) | cells(30,4,1)) : cells(0,2,1)};
    vecs[8] = '{"row_wrap_horiz", {7'd0,7'd0,7'd0,7'd0,7'd8}, 5'b00000, {3'd0,3'd0,3'd0,3'd0,3'd3},
                '0, FULL ? 8 : 1, 1'b0, 3'd0, 2'b01, 5'b00001, '0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",     128'(busy),      128'(0));
    chk("reset_done",     128'(done),      128'(0));
    chk("reset_valid",    128'(valid_out), 128'(0));
    chk("reset_err_ship", 128'(err_ship),  128'(0));
    chk("reset_err_code", 128'(err_code),  128'(0));
    chk("reset_err_mask", 128'(err_mask),  128'(0));
    chk("reset_occ_map",  128'(occ_map),   128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      board_blocked = vecs[i].blk;
      load_fleet(vecs[i]);
      run_check(-1, lat);
      check_result(vecs[i].name, lat, vecs[i]);
      board_blocked = '0;
    end

    // start and load while busy are ignored
    load_fleet(vecs[0]);
    run_check(3, lat);
    check_result("start_while_busy", lat, vecs[0]);
    run_check(-1, lat);
    check_result("load_while_busy", lat, vecs[0]);

    // Reset mid-check abandons the check
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_busy",     128'(busy),      128'(0));
    chk("midreset_done",     128'(done),      128'(0));
    chk("midreset_valid",    128'(valid_out), 128'(0));
    chk("midreset_err_code", 128'(err_code),  128'(0));
    chk("midreset_occ_map",  128'(occ_map),   128'(0));
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("midreset_no_done", 128'(saw_done), 128'(0));
    $display("[TB] midreset: busy=%0b done=%0b valid=%0b", busy, done, valid_out);

    // Slots were cleared by reset: empty fleet passes in NUM_SHIPS cycles
    v = '{"empty_fleet", '0, '0, '0, '0, 5, 1'b1, 3'd0, 2'b00, 5'b00000, '0};
    run_check(-1, lat);
    check_result("empty_after_reset", lat, v);

    // load and start in the same cycle: check sees the new slot
    load = 1'b1; load_idx = '0; load_pos = 7'd0; load_vert = 1'b0; load_len = 3'd2;
    v = '{"load_with_start", '0, '0, '0, '0, 7, 1'b1, 3'd0, 2'b00, 5'b00000, cells(0,2,1)};
    run_check(-1, lat);
    check_result("load_with_start", lat, v);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fleet_placement_checker.md
Name: fleet_placement_checker

Overview:
- Parametrised, sequential successor to the combinational ship-placement validator.
- Holds a configurable fleet of ships, each with a position, orientation and length.
- On start, walks every ship cell one per clock and checks board bounds (including row wrap), board-blocked cells and ship overlap.
- Reports pass/fail, the first offending ship and a reason code, plus the resulting occupancy map for the game-state logic.

Parameters:
- BOARD_DIM, 10, board edge; cell index = row*BOARD_DIM + col.
- NUM_SHIPS, 5, fleet slots.
- MAX_LEN, 5, largest legal ship length.
- POS_W, $clog2(BOARD_DIM*BOARD_DIM), width of a cell index.
- IDX_W, $clog2(NUM_SHIPS), width of a ship index.
- LEN_W, $clog2(MAX_LEN+1), width of a ship length.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  write one ship slot; ignored while busy.
- load_idx  in  IDX_W  slot to write; values >= NUM_SHIPS are ignored.
- load_pos  in  POS_W  top-left cell of the ship.
- load_vert  in  1  1 = vertical, 0 = horizontal.
- load_len  in  LEN_W  ship length; 0 = slot unused.
- board_blocked  in  BOARD_DIM*BOARD_DIM  1 = cell unavailable; captured at start.
- start  in  1  begin a check; ignored while busy.
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse when the result is valid.
- valid_out  out  1  last check passed; held until the next start.
- err_ship  out  IDX_W  ship that caused the first error.
- err_code  out  2  00 none, 01 out of bounds, 10 board-blocked, 11 overlap.
- err_mask  out  NUM_SHIPS  per-ship failure flags.
- occ_map  out  BOARD_DIM*BOARD_DIM  cells marked by the last check.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All slots cleared (pos 0, vert 0, len 0).
  - FSM goes to IDLE.
  - busy, done, valid_out, err_ship, err_code, err_mask and occ_map all 0.
  - Reset mid-check abandons the check; no done pulse is produced.
- FSM states: IDLE, BOUND, WALK, DONE.
- IDLE:
  - start=1 captures board_blocked, clears occ_map, err_* and valid_out, sets ship=0 and goes to BOUND.
  - load and start in the same cycle: the slot is written and the check uses the new value.
- BOUND (1 cycle per ship):
  - len==0: skip the ship, no error.
  - Out of bounds (err 01) if any of:
    - len > MAX_LEN;
    - pos >= BOARD_DIM^2;
    - horizontal and col+len > BOARD_DIM;
    - vertical and row+len > BOARD_DIM.
  - Otherwise cell counter k=0 and go to WALK.
- WALK (1 cycle per cell):
  - Cell index = pos+k if horizontal, pos+k*BOARD_DIM if vertical.
  - Check order: blocked first (err 10), then occ_map already set (err 11, charged to the current ship).
  - If no error, set the occ_map bit.
  - After k==len-1, go to the next ship's BOUND; after the last ship, go to DONE.
- Error handling:
  - On the first error, latch err_ship/err_code and set err_mask[ship].
  - Without the optional feature, go to DONE on the next cycle.
- DONE (1 cycle):
  - done=1, busy=0, valid_out = (err_code==00).
  - Then return to IDLE.
- Latency: on a pass, done is high exactly NUM_SHIPS + sum(len) cycles after the start edge (22 for fleet 2,3,3,4,5). An error shortens this.
- busy is high from the cycle after start acceptance until DONE.
- start and load are ignored while busy or in DONE.
- Outputs hold until the next start or reset.

Optional Feature:
- Macro: CHECKER_FULL_SCAN_EN.
- Without it: the check aborts at the first error, and err_mask has at most one bit set.
- With it: the scan always completes and latency is always NUM_SHIPS + sum(len).
  - Every failing ship sets its err_mask bit.
  - A ship that fails BOUND walks no cells.
  - A cell that errors is not marked in occ_map.
  - err_ship/err_code still report the first error; valid_out = ~|err_mask.

Test Plan:
- Fleet lengths 2,3,3,4,5, all horizontal at pos 0,10,20,30,40, no blocked cells, start -> done 22 cycles later; valid_out=1, err_code=00; occ_map bits {0,1,10-12,20-22,30-33,40-44} set.
- Same fleet but ship4 horizontal at pos 97 -> done at cycle 17; err_ship=4, err_code=01, valid_out=0, err_mask=5'b10000.
- Ship0 horizontal at 0, ship1 vertical at 1 -> done at cycle 5; err_ship=1, err_code=11.
- Valid fleet with board_blocked[44]=1 -> err_ship=4, err_code=10, done at cycle 22.
- Protocol and reset:
  - start pulsed while busy: no effect.
  - load while busy: slot unchanged on the next check.
  - rst_n=0 at cycle 8 of a check: busy, done and valid_out are 0 and no done pulse follows.
- With CHECKER_FULL_SCAN_EN, ship4 at 97 and ship1 overlapping ship0 -> done at cycle 22; err_mask=5'b10010, err_ship=1, err_code=11.
